// File: rtl/pipe_redirect_ctrl.sv
// pipe_redirect_ctrl: stall/redirect sequencer for the 5-stage pipeline.
// Folds D-cache stalls, I-cache stalls, load-use hazards and EX redirects
// into per-stage enables and flushes. A redirect that resolves while fetch
// is stalled is parked in pend_pc and issued once fetch frees up.
//
// state      | meaning
// -----------+----------------------------------------------------------
// RUN        | normal flow; same-cycle redirects issue directly
// WAIT_FETCH | redirect parked in pend_pc, waiting for the I-cache
// HALTED     | HALT retired; pipeline frozen until reset
module pipe_redirect_ctrl (
  input  logic        clk,
  input  logic        rst,
  input  logic        icache_stall,
  input  logic        dcache_stall,
  input  logic        load_use,
  input  logic        br_valid,
  input  logic [15:0] br_target,
  input  logic        halt,
  output logic        pc_en,
  output logic        redirect_valid,
  output logic [15:0] redirect_pc,
  output logic        ifid_en,
  output logic        idex_en,
  output logic        exmem_en,
  output logic        ifid_flush,
  output logic        idex_flush,
  output logic        redir_pending,
  output logic        halted,
  output logic [15:0] stall_cycles,
  output logic [7:0]  redir_count
);

  typedef enum logic [1:0] {
    RUN        = 2'd0,
    WAIT_FETCH = 2'd1,
    HALTED     = 2'd2
  } state_t;

  state_t      r_state;
  logic [15:0] r_pend_pc;
  logic [15:0] r_stall_cycles;
  logic [7:0]  r_redir_count;

  // Combinational per-cycle controls; everything forced to 0 while in reset.
  always_comb begin
    pc_en          = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc    = 16'h0000;
    ifid_en        = 1'b0;
    idex_en        = 1'b0;
    exmem_en       = 1'b0;
    ifid_flush     = 1'b0;
    idex_flush     = 1'b0;
    redir_pending  = 1'b0;
    halted         = 1'b0;
    if (rst) begin
      redirect_pc = r_pend_pc;
      case (r_state)
        HALTED: begin
          halted = 1'b1;
        end
        WAIT_FETCH: begin
          redir_pending = 1'b1;
          if (dcache_stall) begin
            // whole pipe frozen, redirect stays parked
          end else if (icache_stall) begin
            ifid_flush = 1'b1;
            idex_flush = 1'b1;
            idex_en    = 1'b1;
            exmem_en   = 1'b1;
          end else begin
            // fetch returned the wrong-path word; flush it and steer the PC
            redirect_valid = 1'b1;
            pc_en          = 1'b1;
            ifid_en        = 1'b1;
            idex_en        = 1'b1;
            exmem_en       = 1'b1;
            ifid_flush     = 1'b1;
            idex_flush     = 1'b1;
          end
        end
        default: begin
          if (dcache_stall) begin
            // EX is frozen and will re-present any branch next cycle
          end else if (br_valid && !icache_stall) begin
            redirect_valid = 1'b1;
            redirect_pc    = br_target;
            pc_en          = 1'b1;
            ifid_en        = 1'b1;
            idex_en        = 1'b1;
            exmem_en       = 1'b1;
            ifid_flush     = 1'b1;
            idex_flush     = 1'b1;
          end else if (br_valid) begin
            ifid_flush = 1'b1;
            idex_flush = 1'b1;
            idex_en    = 1'b1;
            exmem_en   = 1'b1;
          end else if (load_use) begin
            idex_flush = 1'b1;
            exmem_en   = 1'b1;
          end else if (icache_stall) begin
            ifid_flush = 1'b1;
            idex_en    = 1'b1;
            exmem_en   = 1'b1;
          end else begin
            pc_en    = 1'b1;
            ifid_en  = 1'b1;
            idex_en  = 1'b1;
            exmem_en = 1'b1;
          end
        end
      endcase
    end
  end

  // State transitions and parking of a redirect that hit a fetch stall.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state   <= RUN;
      r_pend_pc <= 16'h0000;
    end else begin
      case (r_state)
        HALTED: r_state <= HALTED;
        WAIT_FETCH: begin
          if (halt)
            r_state <= HALTED;
          else if (!dcache_stall && !icache_stall)
            r_state <= RUN;
        end
        default: begin
          if (!dcache_stall && br_valid && icache_stall)
            r_pend_pc <= br_target;
          if (halt)
            r_state <= HALTED;
          else if (!dcache_stall && br_valid && icache_stall)
            r_state <= WAIT_FETCH;
        end
      endcase
    end
  end

  // Statistics: saturating stall counter, wrapping redirect counter.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_stall_cycles <= 16'h0000;
      r_redir_count  <= 8'h00;
    end else begin
      if ((r_state != HALTED) && !pc_en && (r_stall_cycles != 16'hFFFF))
        r_stall_cycles <= r_stall_cycles + 16'h0001;
      if (redirect_valid)
        r_redir_count <= r_redir_count + 8'h01;
    end
  end

  assign stall_cycles = r_stall_cycles;
  assign redir_count  = r_redir_count;

endmodule
